// File: rtl/ddr4a_port_arbiter.sv
// Two-requester arbiter for the shared DDR4A host port: round-robin grant, write-burst
// lock, and an in-order read tag FIFO that steers returning beats to their requester.
module ddr4a_port_arbiter #(
   parameter int ADDR_W    = 33,
   parameter int DATA_W    = 512,
   parameter int BE_W      = 64,
   parameter int RSP_DEPTH = 8
) (
   input  logic                         mu_clk_clk,
   input  logic                         host_reset_reset,
   input  logic [ADDR_W-1:0]            m0_address,
   input  logic                         m0_read,
   input  logic                         m0_write,
   input  logic [DATA_W-1:0]            m0_writedata,
   input  logic [BE_W-1:0]              m0_byteenable,
   input  logic [2:0]                   m0_burstcount,
   output logic                         m0_waitrequest,
   output logic [DATA_W-1:0]            m0_readdata,
   output logic                         m0_readdatavalid,
   input  logic [ADDR_W-1:0]            m1_address,
   input  logic                         m1_read,
   input  logic                         m1_write,
   input  logic [DATA_W-1:0]            m1_writedata,
   input  logic [BE_W-1:0]              m1_byteenable,
   input  logic [2:0]                   m1_burstcount,
   output logic                         m1_waitrequest,
   output logic [DATA_W-1:0]            m1_readdata,
   output logic                         m1_readdatavalid,
   output logic [ADDR_W-1:0]            ddr_address,
   output logic                         ddr_read,
   output logic                         ddr_write,
   output logic [DATA_W-1:0]            ddr_writedata,
   output logic [BE_W-1:0]              ddr_byteenable,
   output logic [2:0]                   ddr_burstcount,
   input  logic                         ddr_waitrequest,
   input  logic [DATA_W-1:0]            ddr_readdata,
   input  logic                         ddr_readdatavalid,
   output logic [$clog2(RSP_DEPTH):0]   rsp_count,
   output logic                         err_unexpected_rsp
);
   localparam int PW = $clog2(RSP_DEPTH);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
   localparam logic [PW:0]   CNT_FULL = (PW+1)'(RSP_DEPTH);

   typedef enum logic {IDLE, WLOCK} state_t;
   typedef struct packed {
      logic       id;
      logic [2:0] bc;
   } tag_t;

   state_t        state, state_nxt;
   logic [2:0]    beats_left, beats_left_nxt;
   logic          last, last_nxt;
   logic          gnt, gnt_vld, sel_read, sel_write, rd_ok, wr_ok, gnt_wait, accept;
   logic [2:0]    sel_bc_raw, sel_bc;
   tag_t          fifo [RSP_DEPTH];
   tag_t          head;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   count;
   logic [2:0]    beat_cnt;
   logic          fifo_full, fifo_empty, push, pop, rsp_hit;

   assign fifo_full  = (count == CNT_FULL);
   assign fifo_empty = (count == '0);
   assign head       = fifo[rd_ptr];
   assign rsp_count  = count;

   // While locked, 'last' already names the burst owner, so it doubles as the lock id.
   always_comb begin
      gnt     = last;
      gnt_vld = 1'b0;
      if (state == WLOCK) begin
         gnt_vld = 1'b1;
      end else begin
         gnt_vld = m0_read | m0_write | m1_read | m1_write;
         if ((m0_read | m0_write) && (m1_read | m1_write)) gnt = ~last;
         else                                               gnt = m1_read | m1_write;
      end
      sel_read   = gnt ? m1_read       : m0_read;
      sel_write  = gnt ? m1_write      : m0_write;
      sel_bc_raw = gnt ? m1_burstcount : m0_burstcount;
      sel_bc     = (sel_bc_raw == 3'd0) ? 3'd1 : sel_bc_raw;
      rd_ok      = gnt_vld & sel_read & ~fifo_full & (state == IDLE) & ~host_reset_reset;
      wr_ok      = gnt_vld & sel_write & ~host_reset_reset;
      gnt_wait   = ddr_waitrequest | ~(rd_ok | wr_ok);
      accept     = (rd_ok | wr_ok) & ~ddr_waitrequest;

      ddr_read       = rd_ok;
      ddr_write      = wr_ok;
      ddr_address    = gnt ? m1_address    : m0_address;
      ddr_writedata  = gnt ? m1_writedata  : m0_writedata;
      ddr_byteenable = gnt ? m1_byteenable : m0_byteenable;
      ddr_burstcount = sel_bc;
      m0_waitrequest = gnt | gnt_wait;
      m1_waitrequest = ~gnt | gnt_wait;
   end

   always_comb begin
      state_nxt      = state;
      beats_left_nxt = beats_left;
      last_nxt       = last;
      unique case (state)
         IDLE: if (accept) begin
            last_nxt = gnt;
            if (wr_ok && sel_bc > 3'd1) begin
               state_nxt      = WLOCK;
               beats_left_nxt = sel_bc - 3'd1;
            end
         end
         WLOCK: if (accept) begin
            beats_left_nxt = beats_left - 3'd1;
            if (beats_left == 3'd1) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Response steering: beats follow the head tag; the last beat of a burst retires it.
   always_comb begin
      push             = accept & rd_ok;
      rsp_hit          = ddr_readdatavalid & ~fifo_empty & ~host_reset_reset;
      pop              = rsp_hit & (beat_cnt == head.bc - 3'd1);
      m0_readdatavalid = rsp_hit & ~head.id;
      m1_readdatavalid = rsp_hit & head.id;
   end

   assign m0_readdata = ddr_readdata;
   assign m1_readdata = ddr_readdata;

   always_ff @(posedge mu_clk_clk) begin
      if (push) fifo[wr_ptr] <= '{id: gnt, bc: sel_bc};
   end

   always_ff @(posedge mu_clk_clk) begin
      if (host_reset_reset) begin
         state              <= IDLE;
         beats_left         <= '0;
         last               <= 1'b1;
         wr_ptr             <= '0;
         rd_ptr             <= '0;
         count              <= '0;
         beat_cnt           <= '0;
         err_unexpected_rsp <= 1'b0;
      end else begin
         state      <= state_nxt;
         beats_left <= beats_left_nxt;
         last       <= last_nxt;
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop) begin
            rd_ptr   <= rd_ptr + PTR_ONE;
            beat_cnt <= '0;
         end else if (rsp_hit) begin
            beat_cnt <= beat_cnt + 3'd1;
         end
         if (push && !pop)      count <= count + CNT_ONE;
         else if (pop && !push) count <= count - CNT_ONE;
         if (ddr_readdatavalid && fifo_empty) err_unexpected_rsp <= 1'b1;
      end
   end
endmodule

// File: tb/tb_ddr4a_port_arbiter.sv
// Randomised scoreboard bench: requester/DDR stimulus pushes expectations, a negedge
// monitor checks the port against a queue-based model of the arbitration rules.
module tb_ddr4a_port_arbiter;
   localparam int AW = 16, DW = 32, BW = 4, DEPTH = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [AW-1:0] m_address [2];
   logic          m_read [2], m_write [2];
   logic [DW-1:0] m_wdata [2];
   logic [BW-1:0] m_be [2];
   logic [2:0]    m_bc [2];
   logic          m_wait [2];
   logic [DW-1:0] m_rdata [2];
   logic          m_rvalid [2];
   logic [AW-1:0] ddr_address;
   logic          ddr_read, ddr_write, ddr_waitrequest, ddr_readdatavalid;
   logic [DW-1:0] ddr_writedata, ddr_readdata;
   logic [BW-1:0] ddr_byteenable;
   logic [2:0]    ddr_burstcount;
   logic [3:0]    rsp_count;
   logic          err_unexpected_rsp;

   ddr4a_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .RSP_DEPTH(DEPTH)) dut (
      .mu_clk_clk(clk), .host_reset_reset(rst),
      .m0_address(m_address[0]), .m0_read(m_read[0]), .m0_write(m_write[0]),
      .m0_writedata(m_wdata[0]), .m0_byteenable(m_be[0]), .m0_burstcount(m_bc[0]),
      .m0_waitrequest(m_wait[0]), .m0_readdata(m_rdata[0]), .m0_readdatavalid(m_rvalid[0]),
      .m1_address(m_address[1]), .m1_read(m_read[1]), .m1_write(m_write[1]),
      .m1_writedata(m_wdata[1]), .m1_byteenable(m_be[1]), .m1_burstcount(m_bc[1]),
      .m1_waitrequest(m_wait[1]), .m1_readdata(m_rdata[1]), .m1_readdatavalid(m_rvalid[1]),
      .ddr_address(ddr_address), .ddr_read(ddr_read), .ddr_write(ddr_write),
      .ddr_writedata(ddr_writedata), .ddr_byteenable(ddr_byteenable),
      .ddr_burstcount(ddr_burstcount), .ddr_waitrequest(ddr_waitrequest),
      .ddr_readdata(ddr_readdata), .ddr_readdatavalid(ddr_readdatavalid),
      .rsp_count(rsp_count), .err_unexpected_rsp(err_unexpected_rsp)
   );

   typedef struct {
      logic [AW-1:0] addr;
      bit            wr;
      logic [DW-1:0] data;
      logic [BW-1:0] be;
      int            n;
   } cmd_t;
   typedef struct {
      int id;
      int left;
   } tag_t;

   cmd_t          exp_cmd0 [$], exp_cmd1 [$];
   logic [DW-1:0] exp_rsp0 [$], exp_rsp1 [$];
   tag_t          tags [$];
   int  last = 1, lock_left = 0, lock_id = 0, owner = -1;
   bit  err_m = 0, rst_prev = 0;
   bit  acc [2];
   bit  busy [2];
   int  wl [2];
   int  p_req0, p_req1, p_wr, p_wait, p_rsp, p_unexp;
   int  errors = 0, checks = 0;

   function automatic int nrm(logic [2:0] b);
      return (b == 3'd0) ? 1 : int'(b);
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_cmd(int m, cmd_t c);
      if (m == 0) exp_cmd0.push_back(c);
      else        exp_cmd1.push_back(c);
   endtask

   task automatic new_beat(int m);
      cmd_t c;
      m_wdata[m] = $urandom;
      m_be[m]    = BW'($urandom);
      c.addr = m_address[m]; c.wr = 1; c.data = m_wdata[m]; c.be = m_be[m]; c.n = nrm(m_bc[m]);
      push_cmd(m, c);
   endtask

   // Avalon-style requester: holds each beat until the model says it was taken.
   task automatic drive_master(int m, int p_req);
      cmd_t c;
      if (acc[m]) begin
         if (m_write[m] && wl[m] > 1) begin
            wl[m]--;
            new_beat(m);
            return;
         end
         busy[m] = 0; m_read[m] = 0; m_write[m] = 0;
      end
      if (!busy[m] && $urandom_range(99) < p_req) begin
         busy[m] = 1;
         m_address[m] = AW'($urandom);
         m_bc[m] = 3'($urandom_range(4));
         if ($urandom_range(99) < p_wr) begin
            m_write[m] = 1; m_read[m] = 0; wl[m] = nrm(m_bc[m]);
            new_beat(m);
         end else begin
            m_read[m] = 1; m_write[m] = 0;
            c.addr = m_address[m]; c.wr = 0; c.data = '0; c.be = '0; c.n = nrm(m_bc[m]);
            push_cmd(m, c);
         end
      end
   endtask

   task automatic respond();
      ddr_readdatavalid = 0; owner = -1;
      if (rst) return;
      if (tags.size() != 0 && $urandom_range(99) < p_rsp) begin
         ddr_readdatavalid = 1; ddr_readdata = $urandom; owner = tags[0].id;
         if (owner == 0) exp_rsp0.push_back(ddr_readdata);
         else            exp_rsp1.push_back(ddr_readdata);
      end else if (tags.size() == 0 && $urandom_range(99) < p_unexp) begin
         ddr_readdatavalid = 1; ddr_readdata = $urandom; owner = -2;
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
      ddr_waitrequest = ($urandom_range(99) < p_wait);
      if (!rst) begin
         drive_master(0, p_req0);
         drive_master(1, p_req1);
      end
      respond();
   endtask

   // Monitor / reference model
   int            g;
   bit            vld, lk, full, r0, r1, e_rd, e_wr, take;
   cmd_t          c;
   tag_t          h;
   logic [DW-1:0] d;
   initial forever begin
      @(negedge clk);
      acc[0] = 0; acc[1] = 0;
      if (rst) begin
         chk("rst_ddr_read", 64'(ddr_read), 64'(0));
         chk("rst_ddr_write", 64'(ddr_write), 64'(0));
         chk("rst_m0_waitrequest", 64'(m_wait[0]), 64'(1));
         chk("rst_m1_waitrequest", 64'(m_wait[1]), 64'(1));
         chk("rst_m0_readdatavalid", 64'(m_rvalid[0]), 64'(0));
         chk("rst_m1_readdatavalid", 64'(m_rvalid[1]), 64'(0));
         if (rst_prev) begin
            chk("rst_rsp_count", 64'(rsp_count), 64'(0));
            chk("rst_err", 64'(err_unexpected_rsp), 64'(0));
         end
         tags.delete(); lock_left = 0; last = 1; err_m = 0; rst_prev = 1;
         continue;
      end
      rst_prev = 0;
      r0 = m_read[0] | m_write[0];
      r1 = m_read[1] | m_write[1];
      full = (tags.size() == DEPTH);
      chk("rsp_count", 64'(rsp_count), 64'(tags.size()));
      chk("err_unexpected_rsp", 64'(err_unexpected_rsp), 64'(err_m));
      lk = (lock_left > 0);
      vld = lk || r0 || r1;
      if (lk)            g = lock_id;
      else if (r0 && r1) g = (last == 0) ? 1 : 0;
      else               g = r0 ? 0 : 1;
      e_rd = vld && !lk && m_read[g] && !full;
      e_wr = vld && m_write[g];
      take = (e_rd || e_wr) && !ddr_waitrequest;
      chk("ddr_read", 64'(ddr_read), 64'(e_rd));
      chk("ddr_write", 64'(ddr_write), 64'(e_wr));
      chk("m0_waitrequest", 64'(m_wait[0]), 64'(!(take && g == 0)));
      chk("m1_waitrequest", 64'(m_wait[1]), 64'(!(take && g == 1)));
      if (take) begin
         if ((g == 0 && exp_cmd0.size() == 0) || (g == 1 && exp_cmd1.size() == 0)) begin
            chk("cmd_queue_nonempty", 64'(0), 64'(1));
         end else begin
            c = (g == 0) ? exp_cmd0.pop_front() : exp_cmd1.pop_front();
            chk("ddr_address", 64'(ddr_address), 64'(c.addr));
            chk("ddr_burstcount", 64'(ddr_burstcount), 64'(c.n));
            if (c.wr) begin
               chk("ddr_writedata", 64'(ddr_writedata), 64'(c.data));
               chk("ddr_byteenable", 64'(ddr_byteenable), 64'(c.be));
            end
            acc[g] = 1;
            if (lk) lock_left--;
            else begin
               last = g;
               if (e_wr && c.n > 1) begin lock_id = g; lock_left = c.n - 1; end
            end
            if (e_rd) begin h.id = g; h.left = c.n; tags.push_back(h); end
         end
      end
      chk("m0_readdatavalid", 64'(m_rvalid[0]), 64'(owner == 0));
      chk("m1_readdatavalid", 64'(m_rvalid[1]), 64'(owner == 1));
      if (owner >= 0) begin
         d = (owner == 0) ? exp_rsp0.pop_front() : exp_rsp1.pop_front();
         chk(owner == 0 ? "m0_readdata" : "m1_readdata", 64'(m_rdata[owner]), 64'(d));
         h = tags[0];
         h.left--;
         if (h.left == 0) void'(tags.pop_front());
         else             tags[0] = h;
      end else if (owner == -2) begin
         err_m = 1;
      end
   end

   task automatic do_reset();
      int n = 0;
      while (lock_left != 2 && n < 400) begin step(); n++; end
      rst = 1; ddr_readdatavalid = 0; owner = -1;
      step(); step();
      @(posedge clk); #1;
      rst = 0;
      for (int m = 0; m < 2; m++) begin busy[m] = 0; m_read[m] = 0; m_write[m] = 0; end
      exp_cmd0.delete(); exp_cmd1.delete(); exp_rsp0.delete(); exp_rsp1.delete();
      ddr_readdatavalid = 0; owner = -1;
   endtask

   initial begin
      int n;
      rst = 1;
      for (int m = 0; m < 2; m++) begin
         m_address[m] = '0; m_read[m] = 0; m_write[m] = 0; m_wdata[m] = '0;
         m_be[m] = '0; m_bc[m] = '0; busy[m] = 0; wl[m] = 0;
      end
      ddr_waitrequest = 0; ddr_readdata = '0; ddr_readdatavalid = 0;
      p_req0 = 0; p_req1 = 0; p_wr = 0; p_wait = 0; p_rsp = 0; p_unexp = 0;
      repeat (3) step();
      rst = 0;
      for (int s = 0; s < 12; s++) begin
         p_req0  = $urandom_range(20, 95);
         p_req1  = $urandom_range(20, 95);
         p_wr    = (s == 1 || s == 5) ? 0 : $urandom_range(10, 60);
         p_wait  = $urandom_range(0, 40);
         p_rsp   = (s % 4 == 1) ? 0 : $urandom_range(20, 100);
         p_unexp = (s == 3 || s == 8) ? 10 : 0;
         repeat (300) step();
         if (s % 3 == 2) begin
            p_wr = 70; p_req0 = 90; p_req1 = 90;
            do_reset();
         end
      end
      p_req0 = 0; p_req1 = 0; p_wait = 0; p_rsp = 100; p_unexp = 0;
      n = 0;
      while ((busy[0] || busy[1] || tags.size() != 0) && n < 3000) begin step(); n++; end
      checks++;
      if (n >= 3000) begin
         errors++;
         $display("FAIL drain_timeout: %0d tags still outstanding, required 0", tags.size());
      end
      repeat (4) step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
